// File: rtl/piso_serializer.sv
// ============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in serial-out stage with a one-word holding buffer,
//            start-of-word strobe and bit-valid qualifier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out,
  output logic         out_valid,
  output logic         sof,
  output logic         busy
);

  localparam int              c_cw   = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_shreg;
  logic [N-1:0]    r_hold;
  logic            r_hold_full;
  logic [c_cw-1:0] r_cnt;

  logic [N-1:0]    w_shifted;
  logic            w_out;
  logic            w_accept;

  // Shift toward whichever end feeds the serial output; vacated bits fill with 0
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_shreg[N-2:0], 1'b0};
      assign w_out     = r_shreg[N-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_shreg[N-1:1]};
      assign w_out     = r_shreg[0];
    end
  endgenerate

  assign in_ready  = !r_hold_full;
  assign w_accept  = in_valid && !r_hold_full;
  assign out       = w_out;
  assign out_valid = (r_state == SHIFT);
  assign sof       = (r_state == SHIFT) && (r_cnt == '0);
  assign busy      = (r_state == SHIFT) || r_hold_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= in_data;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt != c_last) begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt + 1'b1;
            if (w_accept) begin
              r_hold      <= in_data;
              r_hold_full <= 1'b1;
            end
          end else if (r_hold_full) begin
            r_shreg     <= r_hold;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
          end else if (w_accept) begin
            r_shreg <= in_data;
            r_cnt   <= '0;
          end else begin
            // Final shift flushes the last bit so the line idles at 0
            r_shreg <= w_shifted;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Scoreboard bench for piso_serializer (MSB-first and LSB-first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din0, din1;
  logic       vin0, vin1;
  logic       rdy0, rdy1;
  logic       so0, so1;
  logic       ov0, ov1;
  logic       sof0, sof1;
  logic       busy0, busy1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] acc0 = '0, acc1 = '0;
  int         bc0 = 0, bc1 = 0;

  piso_serializer #(.N(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(din0), .in_valid(vin0), .in_ready(rdy0),
    .out(so0), .out_valid(ov0), .sof(sof0), .busy(busy0)
  );

  piso_serializer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(din1), .in_valid(vin1), .in_ready(rdy1),
    .out(so1), .out_valid(ov1), .sof(sof1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: deserializes each stream like the downstream SIPO and pops the scoreboard
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      bc0 = 0;
      bc1 = 0;
    end else begin
      if (ov0) begin
        chk("sof_msb", {31'b0, sof0}, {31'b0, bc0 == 0});
        acc0 = {acc0[6:0], so0};
        bc0++;
        if (bc0 == 8) begin
          bc0 = 0;
          if (exp0.size() == 0) begin
            checks++; errors++;
            $display("FAIL word_msb: got unexpected word %0h expected none", acc0);
          end else begin
            e = exp0.pop_front();
            chk("word_msb", {24'b0, acc0}, {24'b0, e});
          end
        end
      end
      if (ov1) begin
        chk("sof_lsb", {31'b0, sof1}, {31'b0, bc1 == 0});
        acc1 = {so1, acc1[7:1]};
        bc1++;
        if (bc1 == 8) begin
          bc1 = 0;
          if (exp1.size() == 0) begin
            checks++; errors++;
            $display("FAIL word_lsb: got unexpected word %0h expected none", acc1);
          end else begin
            e = exp1.pop_front();
            chk("word_lsb", {24'b0, acc1}, {24'b0, e});
          end
        end
      end
    end
  end

  // Present a word and hold in_valid until it is accepted; reports edges waited
  task automatic send(input int sel, input logic [7:0] w, output int waited);
    logic rdy;
    bit   acc;
    waited = 0;
    acc    = 0;
    if (sel == 0) begin din0 = w; vin0 = 1'b1; exp0.push_back(w); end
    else          begin din1 = w; vin1 = 1'b1; exp1.push_back(w); end
    while (!acc && waited < 100) begin
      @(negedge clk);
      rdy = (sel == 0) ? rdy0 : rdy1;
      @(posedge clk);
      waited++;
      if (rdy) acc = 1;
    end
    #1;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", {31'b0, t >= 300}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out"},       {31'b0, so0},   32'd0);
    chk({tag, "_out_valid"}, {31'b0, ov0},   32'd0);
    chk({tag, "_sof"},       {31'b0, sof0},  32'd0);
    chk({tag, "_in_ready"},  {31'b0, rdy0},  32'd1);
    chk({tag, "_busy"},      {31'b0, busy0}, 32'd0);
  endtask

  initial begin
    int w;
    int cnt;
    rst = 1'b0; din0 = 8'h00; din1 = 8'h00; vin0 = 1'b0; vin1 = 1'b0;

    // In-reset stimulus must be ignored
    repeat (2) @(posedge clk);
    #1; vin0 = 1'b1; din0 = 8'hFF; vin1 = 1'b1; din1 = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_lsb_busy", {31'b0, busy1}, 32'd0);
    vin0 = 1'b0; vin1 = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_valid", {31'b0, ov0}, 32'd0);
    @(posedge clk); #1;

    // Single word, timing of last bit and return to idle
    send(0, 8'hA5, w);
    vin0 = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("single_last_valid", {31'b0, ov0},   32'd1);
    chk("single_last_busy",  {31'b0, busy0}, 32'd1);
    chk("single_last_bit",   {31'b0, so0},   32'd1);
    @(negedge clk);
    chk("single_idle_valid", {31'b0, ov0},   32'd0);
    chk("single_idle_busy",  {31'b0, busy0}, 32'd0);
    chk("single_idle_out",   {31'b0, so0},   32'd0);
    drain();
    @(posedge clk); #1;

    // Back-to-back stream with holding buffer
    send(0, 8'hA5, w);
    send(0, 8'h3C, w);
    chk("b2b_hold_wait", w, 32'd1);
    chk("b2b_ready_low", {31'b0, rdy0}, 32'd0);
    send(0, 8'hFF, w);
    chk("b2b_ff_wait", w, 32'd8);
    vin0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov0) cnt++;
    end
    chk("b2b_contiguous", cnt, 32'd15);
    @(negedge clk);
    chk("b2b_end_valid", {31'b0, ov0},   32'd0);
    chk("b2b_end_busy",  {31'b0, busy0}, 32'd0);
    drain();
    @(posedge clk); #1;

    // LSB-first ordering
    send(1, 8'h01, w);
    vin1 = 1'b0;
    @(negedge clk);
    chk("lsb_first_bit", {31'b0, so1},  32'd1);
    chk("lsb_first_sof", {31'b0, sof1}, 32'd1);
    @(posedge clk); #1;
    send(1, 8'h80, w);
    vin1 = 1'b0;
    @(negedge clk);
    chk("lsb_80_first_bit", {31'b0, so1}, 32'd0);
    drain();
    @(posedge clk); #1;

    // Reset in the middle of a word with another word held
    send(0, 8'hA5, w);
    send(0, 8'h3C, w);
    vin0 = 1'b0;
    chk("midrst_busy_before", {31'b0, busy0}, 32'd1);
    repeat (2) @(posedge clk);
    #2; rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp0.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", {31'b0, ov0 | busy0}, 32'd0);
    @(posedge clk); #1;
    send(0, 8'h5A, w);
    vin0 = 1'b0;
    drain();

    chk("final_msb_partial", bc0, 32'd0);
    chk("final_lsb_partial", bc1, 32'd0);
    chk("final_queues", exp0.size() + exp1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
